// File: rtl/register_file_mp.sv
// Parametrised 2-read/1-write register file with registered reads, optional bypass,
// optional hardwired-zero register 0 and a sequenced bulk-clear engine.
module register_file_mp #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter bit BYPASS     = 1'b0,
  parameter bit ZERO_REG0  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] reg_to_write,
  input  logic [DATA_WIDTH-1:0] data_to_write,
  input  logic [ADDR_WIDTH-1:0] reg_to_read1,
  input  logic [ADDR_WIDTH-1:0] reg_to_read2,
  input  logic                  clear_start,
  output logic [DATA_WIDTH-1:0] data_to_read1,
  output logic [DATA_WIDTH-1:0] data_to_read2,
  output logic                  read_valid,
  output logic                  busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_L  = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd1, r_rd2;
  logic                  r_vld;
  logic                  w_busy, w_accept, w_clr_go, w_wr;
  logic [DATA_WIDTH-1:0] w_rd1, w_rd2;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !(ZERO_REG0 && (a == '0));
  endfunction

  // Reads see old contents unless bypass forwards a same-edge write.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] word,
                                                      input logic                  wr);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (in_range(a)) begin
      if (BYPASS && wr && (reg_to_write == a)) v = data_to_write;
      else                                     v = word;
    end
    return v;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (clear_start)      w_next = S_CLEAR;
      S_CLEAR: if (r_cnt == LAST_L)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state == S_CLEAR);
    w_clr_go = (r_state == S_IDLE) && clear_start;
    w_accept = (r_state == S_IDLE) && enable && !clear_start;
    w_wr     = w_accept && load && in_range(reg_to_write);
  end

  always_comb begin
    w_rd1 = read_port(reg_to_read1, r_mem[reg_to_read1[IDX_W-1:0]], w_wr);
    w_rd2 = read_port(reg_to_read2, r_mem[reg_to_read2[IDX_W-1:0]], w_wr);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_cnt <= '0;
    else if (w_clr_go) r_cnt <= '0;
    else if (w_busy)   r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_busy) begin
      r_mem[r_cnt[IDX_W-1:0]] <= '0;
    end else if (w_wr) begin
      r_mem[reg_to_write[IDX_W-1:0]] <= data_to_write;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_vld <= 1'b0;
    end else if (w_accept) begin
      r_rd1 <= w_rd1;
      r_rd2 <= w_rd2;
      r_vld <= 1'b1;
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign data_to_read1 = r_rd1;
  assign data_to_read2 = r_rd2;
  assign read_valid    = r_vld;
  assign busy          = w_busy;

endmodule
